sram_stream_fetch: RTL and testbench

// - Reads ext async SRAM sequentially from address 0 to end_address and buffers the bytes in a small FIFO.
// - The pattern timestep logic pops one byte per timestep from that FIFO.
// - Sits between the ext SRAM address/data mux and the pattern output stage.
// - Decouples SRAM access timing from timestep timing and provides repeat (wrap) playback.

---
 rtl/sram_stream_fetch_pkg.sv | 19 +
 rtl/sram_stream_fetch_fifo.sv | 75 +++++++
 rtl/sram_stream_fetch.sv | 150 +++++++++++++++
 tb/tb_sram_stream_fetch.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_fetch_pkg.sv
// Shared types and defaults for the SRAM stream prefetcher.
// Fetch FSM states plus parameter defaults used by the top level.
package sram_stream_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WAIT,
      CAPT,
      FULL,
      DRAIN
   } fetch_state_t;

   localparam int ADDR_W_DEF     = 19;
   localparam int DATA_W_DEF     = 8;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int RD_WAIT_DEF    = 1;

endpackage

// File: rtl/sram_stream_fetch_fifo.sv
// Small synchronous FIFO with a registered head byte.
// Push and pop may coincide at any fill level; pops on empty are dropped.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] dout_o,
   output logic              empty_o,
   output logic [CW-1:0]     count_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     rd_q, rd_d;
   logic [PW-1:0]     wr_q, wr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              full;
   logic              pop_eff;
   logic              push_eff;

   assign empty_o  = (cnt_q == '0);
   assign full     = (cnt_q == CW'(DEPTH));
   assign pop_eff  = pop_i && !empty_o && !flush_i;
   assign push_eff = push_i && !flush_i && (!full || pop_eff);
   assign dout_o   = dout_q;
   assign count_o  = cnt_q;

   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      dout_d = dout_q;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_eff) wr_d = wr_q + PW'(1);
         if (pop_eff)  rd_d = rd_q + PW'(1);
         cnt_d = cnt_q + CW'(push_eff) - CW'(pop_eff);
         // Head comes from storage, or straight from din when it becomes the only entry
         if (pop_eff && cnt_q > CW'(1))
            dout_d = mem_q[rd_q + PW'(1)];
         else if (push_eff && cnt_q == CW'(pop_eff))
            dout_d = din_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_eff) mem_q[wr_q] <= din_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
      end
   end

endmodule

// File: rtl/sram_stream_fetch.sv
// Sequential async-SRAM reader feeding a prefetch FIFO.
// Supports wrap-around playback, abort, and underrun flagging.
module sram_stream_fetch
   import sram_stream_fetch_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int RD_WAIT    = RD_WAIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              repeat_en,
   input  logic [ADDR_W-1:0] end_address,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_cen,
   output logic              sram_oen,
   input  logic [DATA_W-1:0] sram_data_in,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              busy,
   output logic              done,
   output logic              underrun
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic [7:0]        wcnt_q, wcnt_d;
   logic [DATA_W-1:0] cap_q, cap_d;
   logic              push_q, push_d;
   logic              under_q, under_d;

   logic              flush;
   logic              f_empty;
   logic [CW-1:0]     f_count;
   logic              pop_eff;
   logic [CW:0]       lvl;
   logic              last;
   logic              rd_active;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .flush_i (flush),
      .push_i  (push_q),
      .din_i   (cap_q),
      .pop_i   (pop),
      .dout_o  (dout),
      .empty_o (f_empty),
      .count_o (f_count)
   );

   // Fill level once the pending capture lands and this cycle's pop retires
   assign pop_eff   = pop && !f_empty;
   assign lvl       = {1'b0, f_count} + (CW+1)'(push_q) - (CW+1)'(pop_eff);
   assign last      = (addr_q == end_q);
   assign rd_active = (state_q == ADDR) || (state_q == WAIT) || (state_q == CAPT);

   assign sram_addr  = addr_q;
   assign sram_cen   = !rd_active;
   assign sram_oen   = !rd_active;
   assign dout_valid = !f_empty;
   assign busy       = (state_q != IDLE) || !f_empty || push_q;
   assign underrun   = under_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      end_d   = end_q;
      wcnt_d  = wcnt_q;
      cap_d   = cap_q;
      push_d  = 1'b0;
      under_d = under_q | (pop && f_empty && busy);
      flush   = 1'b0;
      done    = 1'b0;
      if (stop) begin
         state_d = IDLE;
         flush   = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  addr_d  = '0;
                  end_d   = end_address;
                  under_d = 1'b0;
                  state_d = ADDR;
               end
            end
            ADDR: begin
               wcnt_d  = '0;
               state_d = (RD_WAIT == 0) ? CAPT : WAIT;
            end
            WAIT: begin
               if (wcnt_q == 8'(RD_WAIT - 1)) state_d = CAPT;
               else                           wcnt_d  = wcnt_q + 8'd1;
            end
            CAPT: begin
               cap_d  = sram_data_in;
               push_d = 1'b1;
               if (last && !repeat_en) begin
                  state_d = DRAIN;
               end else begin
                  addr_d  = last ? '0 : addr_q + ADDR_W'(1);
                  state_d = (lvl >= (CW+1)'(FIFO_DEPTH - 1)) ? FULL : ADDR;
               end
            end
            FULL: begin
               if (lvl < (CW+1)'(FIFO_DEPTH)) state_d = ADDR;
            end
            DRAIN: begin
               if (f_empty && !push_q) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         end_q   <= '0;
         wcnt_q  <= '0;
         cap_q   <= '0;
         push_q  <= 1'b0;
         under_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         end_q   <= end_d;
         wcnt_q  <= wcnt_d;
         cap_q   <= cap_d;
         push_q  <= push_d;
         under_q <= under_d;
      end
   end

endmodule

// File: tb/tb_sram_stream_fetch.sv
// Scoreboard bench for sram_stream_fetch against a behavioural async SRAM.
// Expected bytes are queued at start and checked as the consumer pops.
module tb_sram_stream_fetch;
   import sram_stream_fetch_pkg::*;

   localparam int AW = 19;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          repeat_en = 1'b0;
   logic [AW-1:0] end_address = '0;
   logic [AW-1:0] sram_addr;
   logic          sram_cen;
   logic          sram_oen;
   logic [DW-1:0] sram_data_in;
   logic          pop = 1'b0;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          busy;
   logic          done;
   logic          underrun;

   int            checks = 0;
   int            fails = 0;
   logic [DW-1:0] exp_q[$];

   sram_stream_fetch #(
      .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .RD_WAIT(1)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .repeat_en(repeat_en), .end_address(end_address),
      .sram_addr(sram_addr), .sram_cen(sram_cen), .sram_oen(sram_oen),
      .sram_data_in(sram_data_in), .pop(pop), .dout(dout),
      .dout_valid(dout_valid), .busy(busy), .done(done),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] patt(input int a);
      return 8'(a * 37 + 11) ^ 8'hA5;
   endfunction

   assign sram_data_in = (!sram_cen && !sram_oen) ?
                         patt(int'(sram_addr[7:0])) : 8'h00;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int ea, input bit rep);
      end_address = AW'(ea);
      repeat_en = rep;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic do_stop;
      stop = 1'b1;
      tick;
      stop = 1'b0;
   endtask

   task automatic test_reset;
      logic [32:0] exp_v;
      logic [32:0] got_v;
      reset = 1'b1;
      tick;
      tick;
      exp_v = {19'd0, 1'b1, 1'b1, 8'd0, 4'b0000};
      got_v = {sram_addr, sram_cen, sram_oen, dout,
               dout_valid, busy, done, underrun};
      checks++;
      if (got_v !== exp_v) begin
         fails++;
         $display("FAIL reset_vals got %h exp %h", got_v, exp_v);
      end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_single_run;
      int k;
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(patt(i));
      do_start(3, 1'b0);
      repeat (3) tick;
      checks++;
      if (dout_valid !== 1'b0) begin
         fails++;
         $display("FAIL lat_early got %b exp 0", dout_valid);
      end
      tick;
      checks++;
      if (dout_valid !== 1'b1) begin
         fails++;
         $display("FAIL lat_first got %b exp 1", dout_valid);
      end
      for (int p = 0; p < 4; p++) begin
         k = 0;
         while (!dout_valid && k < 100) begin tick; k++; end
         repeat (7) tick;
         checks++;
         if (!dout_valid || dout !== exp_q[0]) begin
            fails++;
            $display("FAIL seq_data[%0d] got %h v=%b exp %h",
                     p, dout, dout_valid, exp_q[0]);
         end
         void'(exp_q.pop_front());
         pop = 1'b1;
         tick;
         pop = 1'b0;
      end
      checks++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL seq_done got %b exp 1", done);
      end
      tick;
      checks++;
      if ({busy, done} !== 2'b00) begin
         fails++;
         $display("FAIL seq_idle busy/done got %b exp 00", {busy, done});
      end
   endtask

   task automatic test_repeat;
      int  k;
      bit  dseen;
      dseen = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 9; i++) exp_q.push_back(patt(i % 3));
      do_start(2, 1'b1);
      for (int p = 0; p < 9; p++) begin
         k = 0;
         while (!dout_valid && k < 100) begin
            tick;
            k++;
            if (done) dseen = 1'b1;
         end
         for (int j = 0; j < 3; j++) begin
            tick;
            if (done) dseen = 1'b1;
         end
         checks++;
         if (!dout_valid || dout !== exp_q[0]) begin
            fails++;
            $display("FAIL rep_data[%0d] got %h v=%b exp %h",
                     p, dout, dout_valid, exp_q[0]);
         end
         void'(exp_q.pop_front());
         pop = 1'b1;
         tick;
         pop = 1'b0;
         if (done) dseen = 1'b1;
      end
      checks++;
      if (dseen !== 1'b0) begin
         fails++;
         $display("FAIL rep_nodone got %b exp 0", dseen);
      end
      repeat_en = 1'b0;
      do_stop;
   endtask

   task automatic test_fill_stall;
      int ncapt;
      ncapt = 0;
      do_start(100, 1'b0);
      for (int i = 0; i < 40; i++) begin
         if (dut.state_q == CAPT) ncapt++;
         tick;
      end
      checks++;
      if (ncapt != 4) begin
         fails++;
         $display("FAIL full_capts got %0d exp 4", ncapt);
      end
      checks++;
      if (dut.state_q !== FULL) begin
         fails++;
         $display("FAIL full_state got %0d exp %0d", dut.state_q, FULL);
      end
      checks++;
      if ({sram_cen, sram_oen, sram_addr} !== {2'b11, 19'd4}) begin
         fails++;
         $display("FAIL full_bus got cen=%b oen=%b addr=%0d exp 1 1 4",
                  sram_cen, sram_oen, sram_addr);
      end
      checks++;
      if (!dout_valid || dout !== patt(0)) begin
         fails++;
         $display("FAIL full_head got %h v=%b exp %h",
                  dout, dout_valid, patt(0));
      end
      do_stop;
      checks++;
      if ({dout_valid, busy} !== 2'b00) begin
         fails++;
         $display("FAIL full_flush got %b exp 00", {dout_valid, busy});
      end
   endtask

   task automatic test_underrun;
      logic [DW-1:0] d0;
      int            ncmp;
      ncmp = 0;
      exp_q.delete();
      for (int i = 0; i <= 100; i++) exp_q.push_back(patt(i));
      do_start(100, 1'b0);
      checks++;
      if (underrun !== 1'b0) begin
         fails++;
         $display("FAIL und_init got %b exp 0", underrun);
      end
      d0 = dout;
      pop = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (dout_valid) begin
            ncmp++;
            checks++;
            if (dout !== exp_q[0]) begin
               fails++;
               $display("FAIL und_data got %h exp %h", dout, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
         tick;
         if (i == 0) begin
            checks++;
            if ({underrun, dout} !== {1'b1, d0}) begin
               fails++;
               $display("FAIL und_set got u=%b d=%h exp u=1 d=%h",
                        underrun, dout, d0);
            end
         end
      end
      pop = 1'b0;
      checks++;
      if (ncmp < 5) begin
         fails++;
         $display("FAIL und_count got %0d exp >=5", ncmp);
      end
      do_stop;
      checks++;
      if (underrun !== 1'b1) begin
         fails++;
         $display("FAIL und_sticky got %b exp 1", underrun);
      end
      do_start(100, 1'b0);
      checks++;
      if (underrun !== 1'b0) begin
         fails++;
         $display("FAIL und_clear got %b exp 0", underrun);
      end
      do_stop;
   endtask

   task automatic test_stop;
      bit dseen;
      bit cen_lo;
      dseen = 1'b0;
      cen_lo = 1'b0;
      do_start(100, 1'b0);
      repeat (9) tick;
      do_stop;
      checks++;
      if ({dout_valid, sram_cen, busy} !== 3'b010) begin
         fails++;
         $display("FAIL stop_now got v/cen/busy %b exp 010",
                  {dout_valid, sram_cen, busy});
      end
      for (int i = 0; i < 10; i++) begin
         tick;
         if (done) dseen = 1'b1;
         if (!sram_cen) cen_lo = 1'b1;
      end
      checks++;
      if ({dseen, cen_lo} !== 2'b00) begin
         fails++;
         $display("FAIL stop_quiet got done/cen_lo %b exp 00", {dseen, cen_lo});
      end
      end_address = AW'(5);
      start = 1'b1;
      stop = 1'b1;
      tick;
      start = 1'b0;
      stop = 1'b0;
      repeat (5) tick;
      checks++;
      if ({busy, sram_cen, dout_valid} !== 3'b010) begin
         fails++;
         $display("FAIL ss_idle got busy/cen/v %b exp 010",
                  {busy, sram_cen, dout_valid});
      end
   endtask

   task automatic test_reset_mid;
      logic [32:0] exp_v;
      logic [32:0] got_v;
      int          k;
      do_start(100, 1'b0);
      tick;
      checks++;
      if (sram_cen !== 1'b0 || dut.state_q !== WAIT) begin
         fails++;
         $display("FAIL rm_wait got cen=%b st=%0d exp 0 %0d",
                  sram_cen, dut.state_q, WAIT);
      end
      #1;
      reset = 1'b1;
      #1;
      exp_v = {19'd0, 1'b1, 1'b1, 8'd0, 4'b0000};
      got_v = {sram_addr, sram_cen, sram_oen, dout,
               dout_valid, busy, done, underrun};
      checks++;
      if (got_v !== exp_v) begin
         fails++;
         $display("FAIL rm_async got %h exp %h", got_v, exp_v);
      end
      tick;
      reset = 1'b0;
      tick;
      exp_q.delete();
      exp_q.push_back(patt(0));
      do_start(0, 1'b0);
      k = 0;
      while (!dout_valid && k < 100) begin tick; k++; end
      checks++;
      if (!dout_valid || dout !== exp_q[0]) begin
         fails++;
         $display("FAIL rm_byte got %h v=%b exp %h", dout, dout_valid, exp_q[0]);
      end
      void'(exp_q.pop_front());
      pop = 1'b1;
      tick;
      pop = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL rm_done got %b exp 1", done);
      end
      tick;
      checks++;
      if ({busy, dout_valid, sram_cen, sram_addr} !== {3'b001, 19'd0}) begin
         fails++;
         $display("FAIL rm_end got busy=%b v=%b cen=%b addr=%0d exp 0 0 1 0",
                  busy, dout_valid, sram_cen, sram_addr);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      test_reset;
      test_single_run;
      test_repeat;
      test_fill_stall;
      test_underrun;
      test_stop;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
